// File: rtl/fractal_engine_scheduler.sv
// fractal_engine_scheduler: hands raster-ordered pixel coordinates to a pool of
// escape-time engines round-robin, holds each engine's result in its slot, and
// drains the slots in the same round-robin order. The output stream is
// therefore raster ordered no matter which engine finishes first.
module fractal_engine_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     start,
  output logic                     busy,
  output logic                     frame_done,
  output logic [NUM_ENGINES-1:0]   eng_start,
  output logic [9:0]               eng_x,
  output logic [8:0]               eng_y,
  input  logic [NUM_ENGINES-1:0]   eng_done,
  input  logic [8*NUM_ENGINES-1:0] eng_iter,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_iter,
  output logic                     out_sof,
  output logic                     out_eol
);

  localparam int PW = $clog2(NUM_ENGINES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SL_FREE = 2'd0;
  localparam logic [1:0] SL_BUSY = 2'd1;
  localparam logic [1:0] SL_HELD = 2'd2;

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  logic [1:0]             r_state;
  logic [1:0]             r_slot   [NUM_ENGINES];
  logic [7:0]             r_result [NUM_ENGINES];
  logic [PW-1:0]          r_dptr, r_cptr;
  logic [9:0]             r_dx, r_ox;
  logic [8:0]             r_dy, r_oy;
  logic [NUM_ENGINES-1:0] r_eng_start;
  logic [9:0]             r_eng_x;
  logic [8:0]             r_eng_y;

  logic w_go, w_disp, w_out_valid, w_acc, w_last_disp, w_last_out;

  // Dispatch only into the slot under dptr; a busy slot stalls, never skips,
  // so collect order always matches dispatch order.
  assign w_go        = (r_state == S_IDLE) && start;
  assign w_disp      = (r_state == S_RUN) && (r_slot[r_dptr] == SL_FREE);
  assign w_out_valid = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                       (r_slot[r_cptr] == SL_HELD);
  assign w_acc       = w_out_valid && out_ready;
  assign w_last_disp = (r_dx == X_LAST) && (r_dy == Y_LAST);
  assign w_last_out  = (r_ox == X_LAST) && (r_oy == Y_LAST);

  // Frame sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) r_state <= S_RUN;
        S_RUN:   if (w_disp && w_last_disp) r_state <= S_DRAIN;
        S_DRAIN: if (w_acc && w_last_out) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Dispatch side: round-robin pointer, raster coordinates, registered request
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_dptr      <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_eng_start <= '0;
      r_eng_x     <= '0;
      r_eng_y     <= '0;
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++)
        r_eng_start[i] <= w_disp && (r_dptr == PW'(i));
      if (w_go) begin
        r_dptr <= '0;
        r_dx   <= '0;
        r_dy   <= '0;
      end else if (w_disp) begin
        r_eng_x <= r_dx;
        r_eng_y <= r_dy;
        r_dptr  <= r_dptr + PW'(1);
        if (r_dx == X_LAST) begin
          r_dx <= '0;
          r_dy <= (r_dy == Y_LAST) ? '0 : r_dy + 9'd1;
        end else begin
          r_dx <= r_dx + 10'd1;
        end
      end
    end
  end

  // Collect side: round-robin pointer and output raster coordinates
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cptr <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
    end else if (w_go) begin
      r_cptr <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
    end else if (w_acc) begin
      r_cptr <= r_cptr + PW'(1);
      if (r_ox == X_LAST) begin
        r_ox <= '0;
        r_oy <= (r_oy == Y_LAST) ? '0 : r_oy + 9'd1;
      end else begin
        r_ox <= r_ox + 10'd1;
      end
    end
  end

  // Per-engine slot: FREE -> BUSY on dispatch, BUSY -> HELD on done (result
  // captured), HELD -> FREE on collection. Done pulses outside BUSY are dropped.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        r_slot[i]   <= SL_FREE;
        r_result[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (w_disp && (r_dptr == PW'(i))) begin
          r_slot[i] <= SL_BUSY;
        end else if (w_acc && (r_cptr == PW'(i))) begin
          r_slot[i] <= SL_FREE;
        end else if ((r_slot[i] == SL_BUSY) && eng_done[i]) begin
          r_slot[i]   <= SL_HELD;
          r_result[i] <= eng_iter[8*i +: 8];
        end
      end
    end
  end

  assign eng_start  = r_eng_start;
  assign eng_x      = r_eng_x;
  assign eng_y      = r_eng_y;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign out_valid  = w_out_valid;
  assign out_iter   = r_result[r_cptr];
  assign out_sof    = w_out_valid && (r_ox == 10'd0) && (r_oy == 9'd0);
  assign out_eol    = w_out_valid && (r_ox == X_LAST);

endmodule
